// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port with a built-in clear sequencer (optional stats: FB_WRITE_STATS_EN).
// Writes reach fb_* one cycle after acceptance; ready is combinational, and both requesters are stalled for the duration of a clear.
module fb_write_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              fb_we,
  output logic              fb_ce,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_din
`ifdef FB_WRITE_STATS_EN
  ,
  output logic [15:0]       a_grant_cnt,
  output logic [15:0]       b_grant_cnt,
  output logic [7:0]        clr_cnt
`endif
);

  typedef enum logic {ARB, CLEAR} state_t;

  // One extra counter bit lets DEPTH == 2**ADDR_W finish without wrapping.
  localparam int unsigned      LAST_I   = DEPTH - 1;
  localparam logic [ADDR_W:0]  CLR_LAST = LAST_I[ADDR_W:0];
  localparam logic [ADDR_W:0]  ADDR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              last_b;
  logic [ADDR_W:0]   clr_addr;
  logic [DATA_W-1:0] clr_val;
  logic              a_xfer, b_xfer, clr_last;

  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;
  assign clr_last = (state == CLEAR) && (clr_addr == CLR_LAST);
  assign fb_ce    = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_last)  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // last_b=1 means B won the previous tie-break round, so A is favoured next.
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    clr_busy = (state == CLEAR);
    if (!rst && state == ARB) begin
      a_ready = a_valid && (!b_valid || last_b);
      b_ready = b_valid && (!a_valid || !last_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_din   <= '0;
      clr_done <= 1'b0;
      last_b   <= 1'b1;
      clr_addr <= '0;
      clr_val  <= '0;
    end else begin
      fb_we    <= 1'b0;
      clr_done <= clr_last;
      if (state == ARB) begin
        if (a_xfer) begin
          fb_we    <= 1'b1;
          fb_waddr <= a_addr;
          fb_din   <= a_data;
          last_b   <= 1'b0;
        end else if (b_xfer) begin
          fb_we    <= 1'b1;
          fb_waddr <= b_addr;
          fb_din   <= b_data;
          last_b   <= 1'b1;
        end
        if (clr_start) begin
          clr_val  <= clr_data;
          clr_addr <= '0;
        end
      end else begin
        fb_we    <= 1'b1;
        fb_waddr <= clr_addr[ADDR_W-1:0];
        fb_din   <= clr_val;
        clr_addr <= clr_addr + ADDR_ONE;
      end
    end
  end

`ifdef FB_WRITE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
      clr_cnt     <= '0;
    end else begin
      if (a_xfer && a_grant_cnt != 16'hFFFF) a_grant_cnt <= a_grant_cnt + 16'd1;
      if (b_xfer && b_grant_cnt != 16'hFFFF) b_grant_cnt <= b_grant_cnt + 16'd1;
      if (clr_done && clr_cnt != 8'hFF)      clr_cnt     <= clr_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: expected framebuffer writes are queued by the stimulus and consumed by a monitor.
module tb_fb_write_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid, clr_start;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data, clr_data;
  logic              a_ready, b_ready, clr_busy, clr_done;
  logic              fb_we, fb_ce;
  logic [ADDR_W-1:0] fb_waddr;
  logic [DATA_W-1:0] fb_din;
`ifdef FB_WRITE_STATS_EN
  logic [15:0]       a_grant_cnt, b_grant_cnt;
  logic [7:0]        clr_cnt;
`endif

  fb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .clr_done(clr_done),
    .fb_we(fb_we), .fb_ce(fb_ce), .fb_waddr(fb_waddr), .fb_din(fb_din)
`ifdef FB_WRITE_STATS_EN
    , .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt), .clr_cnt(clr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                at;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   done_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int at);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.at   = at;
    expq.push_back(e);
  endtask

  // Monitor: every framebuffer write must match the head of the queue, on the predicted cycle.
  exp_t m;
  always @(negedge clk) begin
    if (clr_done === 1'b1) done_pulses++;
    if (fb_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)", fb_waddr, fb_din, cyc);
      end else begin
        m = expq.pop_front();
        chk("wr_addr", 32'(fb_waddr), 32'(m.addr));
        chk("wr_data", 32'(fb_din), 32'(m.data));
        chk("wr_cycle", 32'(cyc), 32'(m.at));
      end
    end else if (expq.size() > 0 && expq[0].at <= cyc) begin
      m = expq.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_write: got no write, expected addr %0h data %0h at cycle %0d", m.addr, m.data, m.at);
    end
  end

  task automatic write_one(input bit is_b, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    if (is_b) begin b_valid = 1'b1; b_addr = addr; b_data = data; end
    else      begin a_valid = 1'b1; a_addr = addr; a_data = data; end
    #1;
    chk(is_b ? "b_ready_single" : "a_ready_single", 32'(is_b ? b_ready : a_ready), 1);
    chk(is_b ? "a_ready_idle" : "b_ready_idle", 32'(is_b ? a_ready : b_ready), 0);
    push(addr, data, cyc + 1);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  logic [ADDR_W-1:0] a_tab [3] = '{12'h010, 12'h011, 12'h012};
  logic [DATA_W-1:0] ad_tab[3] = '{4'h1, 4'h2, 4'h6};
  logic [ADDR_W-1:0] b_tab [2] = '{12'h020, 12'h021};
  logic [DATA_W-1:0] bd_tab[2] = '{4'h4, 4'h8};
  bit                win_b [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int c0, ai, bi;
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b0; clr_start = 1'b0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0; clr_data = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_ce", 32'(fb_ce), 1);
    chk("rst_fb_waddr", 32'(fb_waddr), 0);
    chk("rst_fb_din", 32'(fb_din), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    chk("rst_a_ready", 32'(a_ready), 0);

    @(negedge clk);
    rst = 1'b0;
    a_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("idle_fb_we", 32'(fb_we), 0);
      chk("idle_a_ready", 32'(a_ready), 0);
      chk("idle_b_ready", 32'(b_ready), 0);
      chk("idle_clr_busy", 32'(clr_busy), 0);
      chk("idle_fb_waddr", 32'(fb_waddr), 0);
    end

    write_one(1'b0, 12'h123, 4'hA);
    #1;
    chk("a_single_no_ready_after", 32'(a_ready), 0);
    @(negedge clk);
    #1;
    chk("fb_we_drops", 32'(fb_we), 0);

    write_one(1'b1, 12'h456, 4'h3);

    // Both requesters contend; B was granted last, so A starts the alternation.
    ai = 0; bi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_valid = (ai < 3);
      b_valid = (bi < 2);
      if (ai < 3) begin a_addr = a_tab[ai]; a_data = ad_tab[ai]; end
      if (bi < 2) begin b_addr = b_tab[bi]; b_data = bd_tab[bi]; end
      #1;
      chk("rr_a_ready", 32'(a_ready), 32'(!win_b[i]));
      chk("rr_b_ready", 32'(b_ready), 32'(win_b[i]));
      if (win_b[i]) begin push(b_tab[bi], bd_tab[bi], cyc + 1); bi++; end
      else          begin push(a_tab[ai], ad_tab[ai], cyc + 1); ai++; end
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;

    // Clear started together with an A write; a second start mid-clear must be ignored.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 12'h7FF; a_data = 4'h9;
    clr_start = 1'b1; clr_data = 4'h5;
    #1;
    chk("clr_start_a_ready", 32'(a_ready), 1);
    chk("clr_start_busy", 32'(clr_busy), 0);
    c0 = cyc;
    push(12'h7FF, 4'h9, c0 + 1);
    for (int k = 0; k < DEPTH; k++) push(12'(k), 4'h5, c0 + 2 + k);
    for (int j = 1; j <= DEPTH; j++) begin
      @(negedge clk);
      if (j == 1) begin clr_start = 1'b0; clr_data = 4'hF; a_addr = 12'h0AB; a_data = 4'hC; end
      if (j == 100) begin clr_start = 1'b1; clr_data = 4'h3; end
      if (j == 101) clr_start = 1'b0;
      #1;
      chk("clr_busy_high", 32'(clr_busy), 1);
      chk("clr_done_low", 32'(clr_done), 0);
      chk("clr_a_stalled", 32'(a_ready), 0);
    end
    @(negedge clk);
    #1;
    chk("clr_busy_fall", 32'(clr_busy), 0);
    chk("clr_done_pulse", 32'(clr_done), 1);
    chk("a_after_clear", 32'(a_ready), 1);
    push(12'h0AB, 4'hC, cyc + 1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("clr_done_single", 32'(clr_done), 0);

    // Reset during a clear aborts it with no done pulse.
    @(negedge clk);
    clr_start = 1'b1; clr_data = 4'hE;
    #1;
    c0 = cyc;
    for (int k = 0; k < 1999; k++) push(12'(k), 4'hE, c0 + 2 + k);
    for (int j = 1; j <= 2000; j++) begin
      @(negedge clk);
      if (j == 1) clr_start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("abort_fb_we", 32'(fb_we), 0);
    chk("abort_clr_busy", 32'(clr_busy), 0);
    chk("abort_clr_done", 32'(clr_done), 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort_hold_done", 32'(clr_done), 0);
      chk("abort_hold_we", 32'(fb_we), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    a_valid = 1'b1; a_addr = 12'h100; a_data = 4'h1;
    b_valid = 1'b1; b_addr = 12'h200; b_data = 4'h2;
    #1;
    chk("post_rst_tie_a", 32'(a_ready), 1);
    chk("post_rst_tie_b", 32'(b_ready), 0);
    push(12'h100, 4'h1, cyc + 1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("post_rst_b_next", 32'(b_ready), 1);
    push(12'h200, 4'h2, cyc + 1);
    @(negedge clk);
    b_valid = 1'b0;

    write_one(1'b0, 12'h300, 4'h7);
    write_one(1'b0, 12'h301, 4'h8);
    write_one(1'b1, 12'h302, 4'hB);

    @(negedge clk);
    clr_start = 1'b1; clr_data = 4'h0;
    #1;
    c0 = cyc;
    for (int k = 0; k < DEPTH; k++) push(12'(k), 4'h0, c0 + 2 + k);
    @(negedge clk);
    clr_start = 1'b0;
    repeat (DEPTH + 3) @(negedge clk);
    #1;
    chk("done_pulse_total", 32'(done_pulses), 2);
    chk("queue_drained", 32'(expq.size()), 0);
`ifdef FB_WRITE_STATS_EN
    chk("stat_a_grants", 32'(a_grant_cnt), 3);
    chk("stat_b_grants", 32'(b_grant_cnt), 2);
    chk("stat_clears", 32'(clr_cnt), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
